// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-requester round-robin arbiter.
package arb_pkg;

  localparam int N                = 8;
  localparam int IDX_W            = $clog2(N);
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N-1:0]     vec_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: scans req starting at ptr, wrapping 7->0,
// and returns the first requester found. win_valid is low when req is all zero.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  // Walk from the lowest priority back to ptr so the nearest set bit wins last.
  always_comb begin
    idx_t idx;
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + idx_t'(i);
      if (req[idx]) begin
        win_idx   = idx;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter, 8 requesters, one-hot + encoded grant with valid flag.
// A grant is held until the owner pulses done or drops its request; priority
// then rotates to the requester after the owner.
// Optional watchdog: define ARB_TIMEOUT_EN to force release after MAX_HOLD
// busy cycles, reported with a one-cycle timeout pulse.
//
// Handshake: req is level-sensitive and sampled only in IDLE; gnt/gnt_idx/
// gnt_valid are registered and change one edge after the sampled request or
// release; done is a one-cycle pulse honoured only while BUSY.
module rr_arbiter_8to3
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
`ifdef ARB_TIMEOUT_EN
  output logic             timeout,
`endif
  output arb_state_t       dbg_state,
  output logic [IDX_W-1:0] dbg_ptr
);

  arb_state_t state_q, state_d;
  idx_t       ptr_q, ptr_d;
  vec_t       gnt_q, gnt_d;
  idx_t       gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;

  idx_t       win_idx;
  logic       win_valid;
  logic       rel_c;
  logic       force_c;

  rr_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Normal release: owner signals done or withdraws its request.
  assign rel_c = (state_q == BUSY) && (done || !req[gnt_idx_q]);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  // Forced release when this busy cycle is the MAX_HOLD-th; normal release wins.
  assign force_c = (state_q == BUSY) && !rel_c && (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout = timeout_q;
`else
  assign force_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: grab on any request in IDLE, drop back on any release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = BUSY;
      BUSY:    if (rel_c || force_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: grant load, release, pointer rotation.
  always_comb begin
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = '0;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d       = vec_t'(1) << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
        end
      end
      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q + HOLD_W'(1);
        timeout_d = force_c;
`endif
        if (rel_c || force_c) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + idx_t'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, pointer and optional hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: doc/rr_arbiter_8to3.md
# rr_arbiter_8to3

Round-robin arbiter that shares one downstream resource among eight requesters. It produces a one-hot grant, a 3-bit encoded grant index, and an explicit valid flag, so "no grant" can never be confused with "requester 0 granted". It sits between the request lines and any datapath that consumes an 8-to-3 encoded select. The arbiter holds each grant until the owner releases it, then rotates priority.

## Interface
- `N`, 8, number of requesters; fixed at 8 for this revision.
- `IDX_W`, 3, index width, `$clog2(N)`.
- `MAX_HOLD`, 16, watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in 8: request vector, level-sensitive, one bit per requester.
- `done` in 1: single-cycle release pulse from the current owner.
- `gnt` out 8: one-hot grant, registered.
- `gnt_idx` out 3: encoded index of `gnt`, registered.
- `gnt_valid` out 1: high exactly when `gnt` is non-zero.
- `timeout` out 1: one-cycle pulse on forced release. Present only with `ARB_TIMEOUT_EN`.

## Operation
- States:
  - `IDLE`: no owner.
  - `BUSY`: one owner holds the grant.
- Rotating pointer `ptr[2:0]` marks the highest-priority requester. Reset value 0.
- Selection in `IDLE`:
  - Scan `req` from `ptr` upward, wrapping 7→0.
  - The first set bit wins and becomes `win_idx`.
- `IDLE` → `BUSY` when `|req`:
  - `gnt` = `1 << win_idx`, `gnt_idx` = `win_idx`, `gnt_valid` = 1.
- `BUSY` → `IDLE` on release. Release occurs when either:
  - `done` = 1, or
  - `req[gnt_idx]` = 0 (owner withdrew its request).
- On release:
  - `gnt` = 0, `gnt_valid` = 0, `gnt_idx` keeps its last value.
  - `ptr` = `gnt_idx + 1` (mod 8).
- While `BUSY`:
  - New or changed `req` bits are ignored.
  - `done` while `IDLE` is ignored.
- Invariants:
  - `gnt` is zero or one-hot.
  - `gnt_valid` == `|gnt`.
  - `gnt_idx` == encode(`gnt`) whenever valid.
- `req` = 8'h00 → `gnt_valid` stays 0. This is the defined "none" case; `gnt_idx` is not an indication of ownership.
- X on `req`: no requirement, but the bench asserts no X on `gnt_valid` after reset.

## Timing
- Reset (async assert, sync-safe deassert), all outputs:
  - `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0.
  - `ptr` = 0, state `IDLE`.
- Reset mid-grant: outputs clear immediately and asynchronously; no release pulse is produced.
- Grant latency: `req` sampled high at edge k → `gnt_valid` high after edge k.
- Release latency: `done` sampled at edge k → `gnt_valid` low after edge k.
- Turnaround: minimum one `IDLE` cycle between consecutive grants, so an owner gets at most one grant per two cycles.
- Simultaneous `done` and owner `req` drop: a single release, handled as above.
- Fairness: with all 8 requesting continuously, grants are issued in order ptr, ptr+1, … and each requester is served once per 8 grants.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to `BUSY` and increments each `BUSY` cycle.
  - When it reaches `MAX_HOLD` with no release, forced release occurs: same effects as a normal release, plus `timeout` = 1 for one cycle.
  - A normal release in that same cycle takes precedence; no `timeout` pulse.
- `ARB_TIMEOUT_EN` undefined:
  - No counter and no `timeout` port.
  - A grant is held indefinitely until release.

## Structure
- Package `arb_pkg`:
  - `N`, `IDX_W`, `MAX_HOLD` default.
  - `typedef enum logic {IDLE, BUSY} arb_state_t`.
  - Index and vector typedefs.
- Sub-module `rr_pick`: combinational rotate-then-priority-encode.
  - Inputs: `req`, `ptr`.
  - Outputs: `win_idx[2:0]`, `win_valid`.
  - `win_valid` covers the all-zero input case.
- Top level: state register, `ptr`, output registers, optional counter.

## Test plan
- Reset then idle: `req` = 8'h00 for 10 cycles → `gnt_valid` = 0, `gnt` = 0 throughout.
- Single request: `req` = 8'b0000_0100 → one cycle later `gnt` = 8'h04, `gnt_idx` = 2. `done` pulse → `gnt` = 0, `ptr` = 3.
- Round robin: `req` = 8'hFF held, `done` pulsed each time a grant is seen → `gnt_idx` sequence 0,1,2,…,7,0. Grants are separated by one idle cycle.
- Wrap and withdraw:
  - With `ptr` = 6, `req` = 8'b0000_0011 → `gnt_idx` = 0.
  - Drop `req[0]` without `done` → release, `ptr` = 1.
- Reset mid-grant: assert `rst_n` = 0 while `gnt` = 8'h10 → `gnt` = 0 without waiting for a clock edge. After deassert, `req` = 8'h30 → `gnt_idx` = 4.
- With `ARB_TIMEOUT_EN`, `MAX_HOLD` = 4: `req` = 8'h01 held, no `done` → forced release after 4 `BUSY` cycles with a one-cycle `timeout` pulse. Regrant to 0 follows the idle cycle.
